// File: rtl/rv64_multicycle_ctrl_if.sv
// rv64_multicycle_ctrl_if: instruction- and data-memory handshake bundle for the multicycle sequencer
interface rv64_multicycle_ctrl_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    modport master (output imem_req, imem_addr, dmem_req, dmem_we, input imem_ack, imem_rdata, dmem_ack);
    modport slave  (input imem_req, imem_addr, dmem_req, dmem_we, output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/rv64_multicycle_ctrl.sv
// rv64_multicycle_ctrl: FETCH/DECODE/EXECUTE/MEM/WB sequencer for an RV64I core
// Owns pc/ir, drives imem/dmem handshakes, traps on illegal, misaligned or timed-out accesses.
module rv64_multicycle_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rv64_multicycle_ctrl_if.master mem_bus,
    output logic [31:0]            o_ir,
    input  logic [6:0]             i_opcode,
    input  logic [2:0]             i_format,
    input  logic [63:0]            i_imm,
    input  logic                   i_branch_taken,
    input  logic [63:0]            i_alu_result,
    output logic                   o_rf_we,
    output logic [1:0]             o_wb_sel,
    output logic [63:0]            o_pc,
    output logic [2:0]             o_state,
    output logic [63:0]            o_instret,
    output logic                   o_trap,
    output logic [1:0]             o_trap_cause
);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7
    } state_t;
    state_t        r_state;
    logic [63:0]   r_pc, r_instret;
    logic [31:0]   r_ir;
    logic [WW-1:0] r_wait;
    logic          r_imem_req, r_dmem_req, r_dmem_we, r_rf_we, r_trap;
    logic [1:0]    r_wb_sel, r_cause;
    logic          w_load, w_store, w_branch, w_jal, w_jalr, w_timeout;
    logic [63:0]   w_pc4, w_pc_imm, w_br_pc, w_wb_pc;
    assign w_load    = i_opcode == 7'b0000011;
    assign w_store   = i_opcode == 7'b0100011;
    assign w_branch  = i_opcode == 7'b1100011;
    assign w_jal     = i_opcode == 7'b1101111;
    assign w_jalr    = i_opcode == 7'b1100111;
    assign w_pc4     = r_pc + 64'd4;
    assign w_pc_imm  = r_pc + i_imm;
    assign w_br_pc   = i_branch_taken ? w_pc_imm : w_pc4;
    assign w_wb_pc   = w_jal ? w_pc_imm : w_jalr ? (i_alu_result & ~64'd1) : w_pc4;
    assign w_timeout = r_wait == WW'(ACK_TIMEOUT - 1);
    assign mem_bus.imem_req  = r_imem_req;
    assign mem_bus.imem_addr = r_pc;
    assign mem_bus.dmem_req  = r_dmem_req;
    assign mem_bus.dmem_we   = r_dmem_we;
    assign o_ir         = r_ir;
    assign o_rf_we      = r_rf_we;
    assign o_wb_sel     = r_wb_sel;
    assign o_pc         = r_pc;
    assign o_state      = r_state;
    assign o_instret    = r_instret;
    assign o_trap       = r_trap;
    assign o_trap_cause = r_cause;
    // Requests are registered on entry to FETCH/MEM so a misaligned pc never raises imem_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_instret  <= '0;
            r_wait     <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_we    <= 1'b0;
            r_wb_sel   <= 2'd0;
            r_trap     <= 1'b0;
            r_cause    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_wait     <= '0;
                    r_imem_req <= ~|r_pc[1:0];
                end
                S_FETCH:
                    if (|r_pc[1:0]) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'd2;
                    end else if (mem_bus.imem_ack) begin
                        r_ir       <= mem_bus.imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else if (w_timeout) begin
                        r_imem_req <= 1'b0;
                        r_state    <= S_TRAP;
                        r_trap     <= 1'b1;
                        r_cause    <= 2'd3;
                    end else
                        r_wait <= r_wait + WW'(1);
                S_DECODE:
                    if (i_format == 3'd7) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'd1;
                    end else
                        r_state <= S_EXECUTE;
                S_EXECUTE:
                    if (w_load || w_store) begin
                        r_state    <= S_MEM;
                        r_wait     <= '0;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= w_store;
                    end else if (w_branch) begin
                        r_pc       <= w_br_pc;
                        r_instret  <= r_instret + 64'd1;
                        r_state    <= S_FETCH;
                        r_wait     <= '0;
                        r_imem_req <= ~|w_br_pc[1:0];
                    end else begin
                        r_state  <= S_WB;
                        r_rf_we  <= 1'b1;
                        r_wb_sel <= (w_jal || w_jalr) ? 2'd2 : 2'd0;
                    end
                S_MEM:
                    if (mem_bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_pc       <= w_pc4;
                            r_instret  <= r_instret + 64'd1;
                            r_state    <= S_FETCH;
                            r_wait     <= '0;
                            r_imem_req <= ~|w_pc4[1:0];
                        end else begin
                            r_state  <= S_WB;
                            r_rf_we  <= 1'b1;
                            r_wb_sel <= 2'd1;
                        end
                    end else if (w_timeout) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= S_TRAP;
                        r_trap     <= 1'b1;
                        r_cause    <= 2'd3;
                    end else
                        r_wait <= r_wait + WW'(1);
                S_WB: begin
                    r_rf_we    <= 1'b0;
                    r_pc       <= w_wb_pc;
                    r_instret  <= r_instret + 64'd1;
                    r_state    <= S_FETCH;
                    r_wait     <= '0;
                    r_imem_req <= ~|w_wb_pc[1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv64_multicycle_ctrl.sv
// tb_rv64_multicycle_ctrl: directed instruction traces expanded into expected per-cycle outputs
module tb_rv64_multicycle_ctrl;
    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
    localparam int T = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [6:0]  opcode;
    logic [2:0]  format;
    logic [63:0] imm, alu_result, pc, instret;
    logic        branch_taken, rf_we, trap;
    logic [31:0] ir;
    logic [1:0]  wb_sel, trap_cause;
    logic [2:0]  state;
    int checks = 0, fails = 0, rf_idx, req_cnt;
    rv64_multicycle_ctrl_if mb();
    rv64_multicycle_ctrl #(.RESET_PC(RPC), .ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .mem_bus(mb), .o_ir(ir), .i_opcode(opcode), .i_format(format),
        .i_imm(imm), .i_branch_taken(branch_taken), .i_alu_result(alu_result), .o_rf_we(rf_we),
        .o_wb_sel(wb_sel), .o_pc(pc), .o_state(state), .o_instret(instret), .o_trap(trap),
        .o_trap_cause(trap_cause)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic ia; logic [31:0] rd; logic da; logic [6:0] op; logic [2:0] fmt; logic [63:0] imm;
        logic tk; logic [63:0] alu; logic ireq, dreq, dwe, rfwe; logic [1:0] wsel; logic [2:0] st;
        logic tr; logic [1:0] tc; logic [63:0] pc, ret; logic [31:0] ir;
    } rec_t;
    rec_t q[$];
    // architectural model: pc, ir, retired count, trap status, plus the current decoder inputs
    logic [63:0] m_pc, m_ret, c_imm, c_alu;
    logic [31:0] m_ir, c_rd;
    logic        m_trap, c_tk;
    logic [1:0]  m_cause;
    logic [6:0]  c_op;
    logic [2:0]  c_fmt;
    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask
    task automatic push(input logic [2:0] st, input logic ireq, input logic ia, input logic dreq,
                        input logic dwe, input logic da, input logic rfwe, input logic [1:0] wsel);
        rec_t r;
        r.ia = ia; r.rd = c_rd; r.da = da; r.op = c_op; r.fmt = c_fmt; r.imm = c_imm; r.tk = c_tk;
        r.alu = c_alu; r.ireq = ireq; r.dreq = dreq; r.dwe = dwe; r.rfwe = rfwe; r.wsel = wsel;
        r.st = st; r.tr = m_trap; r.tc = m_cause; r.pc = m_pc; r.ret = m_ret; r.ir = m_ir;
        q.push_back(r);
    endtask
    task automatic go_trap(input logic [1:0] cause);
        m_trap = 1'b1;
        m_cause = cause;
        repeat (3) push(3'd7, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask
    // one instruction: fd/md = cycles before imem/dmem ack (>= T means never acked)
    task automatic instr(input logic [31:0] rd, input logic [6:0] op, input logic [2:0] fmt,
                         input logic [63:0] im, input logic tk, input logic [63:0] alu,
                         input int fd, input int md);
        logic ld, sd;
        if (m_trap) return;
        c_rd = rd; c_op = op; c_fmt = fmt; c_imm = im; c_tk = tk; c_alu = alu;
        ld = op == 7'h03;
        sd = op == 7'h23;
        if (m_pc[1:0] != 2'd0) begin
            push(3'd1, 0, 0, 0, 0, 0, 0, 2'd0);
            go_trap(2'd2);
            return;
        end
        for (int i = 0; i <= fd && i < T; i++) push(3'd1, 1, i == fd, 0, 0, 0, 0, 2'd0);
        if (fd >= T) begin go_trap(2'd3); return; end
        m_ir = rd;
        push(3'd2, 0, 0, 0, 0, 0, 0, 2'd0);
        if (fmt == 3'd7) begin go_trap(2'd1); return; end
        push(3'd3, 0, 0, 0, 0, 0, 0, 2'd0);
        if (op == 7'h63) begin
            m_pc = tk ? m_pc + im : m_pc + 64'd4;
            m_ret++;
            return;
        end
        if (ld || sd) begin
            for (int i = 0; i <= md && i < T; i++) push(3'd4, 0, 0, 1, sd, i == md, 0, 2'd0);
            if (md >= T) begin go_trap(2'd3); return; end
            if (sd) begin
                m_pc = m_pc + 64'd4;
                m_ret++;
                return;
            end
        end
        push(3'd5, 0, 0, 0, 0, 0, 1, ld ? 2'd1 : (op == 7'h6f || op == 7'h67) ? 2'd2 : 2'd0);
        m_pc = op == 7'h6f ? m_pc + im : op == 7'h67 ? {alu[63:1], 1'b0} : m_pc + 64'd4;
        m_ret++;
    endtask
    task automatic run(input int n);
        rec_t r;
        logic [235:0] a, e;
        rf_idx = -1;
        req_cnt = 0;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            r = q.pop_front();
            mb.imem_ack = r.ia; mb.imem_rdata = r.rd; mb.dmem_ack = r.da;
            opcode = r.op; format = r.fmt; imm = r.imm; branch_taken = r.tk; alu_result = r.alu;
            a = {mb.imem_req, mb.dmem_req, mb.dmem_req & mb.dmem_we, rf_we, rf_we ? wb_sel : 2'd0,
                 state, trap, trap_cause, pc, instret, ir, mb.imem_req ? mb.imem_addr : 64'd0};
            e = {r.ireq, r.dreq, r.dreq & r.dwe, r.rfwe, r.rfwe ? r.wsel : 2'd0,
                 r.st, r.tr, r.tc, r.pc, r.ret, r.ir, r.ireq ? r.pc : 64'd0};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL cyc%0d act=%h exp=%h", k, a, e);
            end
            if (rf_we && rf_idx < 0) rf_idx = k;
            if (mb.imem_req && rf_idx < 0) req_cnt++;
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        mb.imem_ack = 0; mb.imem_rdata = '0; mb.dmem_ack = 0;
        opcode = '0; format = '0; imm = '0; branch_taken = 0; alu_result = '0;
        @(posedge clk);
        #1;
        chk("rst_ctl", 64'({state, trap, trap_cause, mb.imem_req, mb.dmem_req, rf_we}), 64'd0);
        chk("rst_pc", pc, RPC);
        chk("rst_ret_ir", instret | 64'(ir), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pc = RPC; m_ir = '0; m_ret = '0; m_trap = 0; m_cause = 2'd0;
        c_rd = '0; c_op = '0; c_fmt = '0; c_imm = '0; c_tk = 0; c_alu = '0;
        q.delete();
        push(3'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        do_reset();
        instr(32'h00100093, 7'h13, 3'd1, 64'd1, 0, 64'd0, 1, 0);
        instr(32'h00c000ef, 7'h6f, 3'd5, 64'd12, 0, 64'd0, 0, 0);
        instr(32'hfe000ce3, 7'h63, 3'd3, -64'sd8, 1, 64'd0, 2, 0);
        instr(32'h00003103, 7'h03, 3'd1, 64'd0, 0, 64'd0, 0, 3);
        instr(32'h06009263, 7'h63, 3'd3, 64'd100, 0, 64'd0, 0, 0);
        instr(32'h00203023, 7'h23, 3'd2, 64'd0, 0, 64'd0, 0, 0);
        instr(32'h000080e7, 7'h67, 3'd1, 64'd0, 0, 64'h80000103, 0, 0);
        instr(32'h00100093, 7'h13, 3'd1, 64'd1, 0, 64'd0, 0, 0);
        run(1000);
        chk("addi_req_cycles", 64'(req_cnt), 64'd2);
        chk("addi_rfwe_cycle", 64'(rf_idx), 64'd5);
        chk("jalr_pc", pc, 64'h80000102);
        chk("seg1_instret", instret, 64'd7);
        chk("misalign_cause", 64'({trap, trap_cause, mb.imem_req}), 64'b1100);
        do_reset();
        instr(32'h00100093, 7'h13, 3'd1, 64'd1, 0, 64'd0, 0, 0);
        instr(32'hffffffff, 7'h7f, 3'd7, 64'd0, 0, 64'd0, 0, 0);
        run(1000);
        chk("illegal_cause", 64'({trap, trap_cause}), 64'b101);
        chk("illegal_pc", pc, 64'h80000004);
        chk("illegal_ir", 64'(ir), 64'hffffffff);
        do_reset();
        instr(32'h00100093, 7'h13, 3'd1, 64'd1, 0, 64'd0, 3, 0);
        instr(32'h00100093, 7'h13, 3'd1, 64'd1, 0, 64'd0, 50, 0);
        run(1000);
        chk("timeout_cause", 64'({trap, trap_cause, mb.imem_req}), 64'b1110);
        chk("timeout_ret", instret, 64'd1);
        do_reset();
        instr(32'h00003103, 7'h03, 3'd1, 64'd0, 0, 64'd0, 0, 50);
        run(6);
        chk("mid_mem_dreq", 64'({mb.dmem_req, state}), 64'b1100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dreq", 64'({mb.dmem_req, mb.imem_req, state}), 64'd0);
        chk("async_pc", pc, RPC);
        do_reset();
        instr(32'h00100093, 7'h13, 3'd1, 64'd1, 0, 64'd0, 0, 0);
        run(5);
        chk("recover_pc", pc, 64'h80000004);
        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end
endmodule
